reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
- Parametrised successor register file for the single-cycle/pipelined datapath: one write port, two read ports, configurable data width and depth.
- Adds behaviour the earlier file lacks:
  - asynchronous reset that triggers a hardware clear sweep of every entry;
  - an optional hardwired zero register (x0);
  - optional write-to-read bypass;
  - a flag for writes dropped while the sweep runs.
- Sits between decode (read addresses) and writeback (write port); init_done gates pipeline start.

Parameters:
- DATA_W, 64, width of each register and of the read/write data ports
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register
- BYPASS, 1, 1: a same-cycle write to a read address is forwarded to that read port; 0: the read returns the pre-write value

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous reset, active-high
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- raddr1  input  ADDR_W  read address, port 1
- raddr2  input  ADDR_W  read address, port 2
- rdata1  output  DATA_W  registered read data, port 1
- rdata2  output  DATA_W  registered read data, port 2
- init_done  output  1  high once the clear sweep has completed
- wr_drop  output  1  one-cycle pulse: a write was discarded

Behaviour:
- Reset (async assert, any time, including mid-sweep or mid-operation):
  - state=INIT, sweep counter=0;
  - rdata1=rdata2=0, init_done=0, wr_drop=0;
  - array contents are not required to change at assertion.
- INIT state, one rising edge per entry after rst deasserts:
  - writes 0 to entry[counter], then counter+1;
  - on the edge that clears entry DEPTH-1: state->RUN, init_done->1 (visible the following cycle);
  - sweep length is exactly DEPTH cycles.
- During INIT:
  - external we is ignored; wr_drop=1 for each cycle in which we=1;
  - rdata1/rdata2 are driven 0.
- RUN state:
  - Write is accepted iff we=1 and not (ZERO_REG=1 and waddr=0).
  - A write attempted with ZERO_REG=1, waddr=0, we=1 is discarded and pulses wr_drop.
  - Accepted write updates entry[waddr] at the rising edge.
- Read latency is 1 cycle. At each rising edge, rdataN is loaded with the first matching rule:
  - ZERO_REG=1 and raddrN=0: 0;
  - BYPASS=1, write accepted this cycle, waddr=raddrN: wdata;
  - otherwise: entry[raddrN] as it was before the edge.
- Both read ports are independent; raddr1=raddr2 is legal, and both return identical data.
- wr_drop is registered and is 0 in every cycle without a discard.
- No other state machine states exist; RUN persists until the next rst.
- Widths: no arithmetic; addresses are used modulo DEPTH by construction (no out-of-range case).

Test Plan:
- Reset sweep:
  - Preload via writes in RUN (entry 3=0x1234), assert rst, release.
  - init_done stays 0 for exactly 32 cycles, then 1.
  - A read of entry 3 returns 0.
- Write then read:
  - After init, write entry 5=0xDEADBEEF_00000001.
  - Next cycle raddr1=5: rdata1=0xDEADBEEF_00000001 one cycle later.
  - raddr2=5 in the same cycle gives the same value.
- Bypass:
  - BYPASS=1: we=1, waddr=7, wdata=0xAA and raddr1=7 in the same cycle gives rdata1=0xAA next cycle.
  - BYPASS=0: the same stimulus gives the old value (0 after init).
- Zero register:
  - ZERO_REG=1: write waddr=0, wdata=0xFF gives wr_drop=1 for one cycle; raddr1=0 reads 0.
  - ZERO_REG=0: the same stimulus reads 0xFF.
- Write during INIT:
  - we=1, waddr=9, wdata=0x55 at sweep cycle 2 gives wr_drop=1.
  - After init_done, entry 9 reads 0.
- Reset mid-operation:
  - Assert rst asynchronously between edges while in RUN.
  - rdata1, rdata2 and init_done go 0 immediately, and the full 32-cycle sweep repeats.
  - Parameter sweep DATA_W=32, ADDR_W=4: sweep takes 16 cycles.

Source files
------------

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 1W/2R register file with reset clear sweep
module reg_file_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              init_done,
  output logic              wr_drop
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              zero_hit;
  logic              wr_acc;
  logic [DATA_W-1:0] nxt1, nxt2;

  assign zero_hit = (ZERO_REG != 0) && (waddr == '0);
  assign wr_acc   = (state == RUN) && we && !zero_hit;

  always_comb begin
    nxt1 = mem[raddr1];
    if ((ZERO_REG != 0) && (raddr1 == '0))
      nxt1 = '0;
    else if ((BYPASS != 0) && wr_acc && (waddr == raddr1))
      nxt1 = wdata;
  end

  always_comb begin
    nxt2 = mem[raddr2];
    if ((ZERO_REG != 0) && (raddr2 == '0))
      nxt2 = '0;
    else if ((BYPASS != 0) && wr_acc && (waddr == raddr2))
      nxt2 = wdata;
  end

  // Array has no reset: the sweep clears it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[cnt] <= '0;
    else if (wr_acc)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      rdata1    <= '0;
      rdata2    <= '0;
      init_done <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          rdata1  <= '0;
          rdata2  <= '0;
          wr_drop <= we;
          cnt     <= cnt + 1'b1;
          if (cnt == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          rdata1  <= nxt1;
          rdata2  <= nxt2;
          wr_drop <= we && zero_hit;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed self-checking bench for reg_file_param
module tb_reg_file_param;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;

  logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
  logic [31:0] s_rd1, s_rd2;
  logic        a_done, b_done, c_done, s_done;
  logic        a_drop, b_drop, c_drop, s_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_param dut_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(a_rd1), .rdata2(a_rd2),
    .init_done(a_done), .wr_drop(a_drop));

  reg_file_param #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(b_rd1), .rdata2(b_rd2),
    .init_done(b_done), .wr_drop(b_drop));

  reg_file_param #(.ZERO_REG(0)) dut_c (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(c_rd1), .rdata2(c_rd2),
    .init_done(c_done), .wr_drop(c_drop));

  reg_file_param #(.DATA_W(32), .ADDR_W(4)) dut_s (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr[3:0]), .wdata(wdata[31:0]),
    .raddr1(raddr1[3:0]), .raddr2(raddr2[3:0]), .rdata1(s_rd1), .rdata2(s_rd2),
    .init_done(s_done), .wr_drop(s_drop));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from reset release until each init_done rises; optionally
  // attempts a write during sweep cycle 2.
  task automatic sweep(input bit poke);
    int ca, cs;
    ca = 0;
    cs = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ca == 0 && a_done) ca = i;
      if (cs == 0 && s_done) cs = i;
      if (poke && i == 2) begin
        we = 1'b1; waddr = 5'd9; wdata = 64'h55;
      end
      if (poke && i == 3) begin
        check("init_wr_drop", a_drop, 1);
        check("init_rdata1", a_rd1, 0);
        we = 1'b0;
      end
      if (poke && i == 4) check("init_wr_drop_clear", a_drop, 0);
    end
    check("sweep_len_32", ca, 32);
    check("sweep_len_16", cs, 16);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_rdata1", a_rd1, 0);
    check("rst_init_done", a_done, 0);
    check("rst_wr_drop", a_drop, 0);
    step();
    step();
    rst = 1'b0;
    sweep(1'b1);

    raddr1 = 5'd9;
    step();
    check("init_write_ignored", a_rd1, 0);

    we = 1'b1; waddr = 5'd3; wdata = 64'h1234;
    step();
    we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd3;
    step();
    check("preload_rd1", a_rd1, 64'h1234);
    check("preload_small", s_rd1, 64'h1234);

    #2 rst = 1'b1;
    #1;
    check("midop_rdata1", a_rd1, 0);
    check("midop_rdata2", a_rd2, 0);
    check("midop_init_done", a_done, 0);
    step();
    rst = 1'b0;
    sweep(1'b0);
    step();
    check("swept_entry3", a_rd1, 0);
    check("swept_entry3_small", s_rd2, 0);

    we = 1'b1; waddr = 5'd5; wdata = 64'hDEADBEEF_00000001;
    step();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    step();
    check("wr_rd1", a_rd1, 64'hDEADBEEF_00000001);
    check("wr_rd2", a_rd2, 64'hDEADBEEF_00000001);
    check("wr_rd_small", s_rd1, 64'h00000001);

    we = 1'b1; waddr = 5'd7; wdata = 64'hAA; raddr1 = 5'd7;
    step();
    we = 1'b0;
    check("bypass_on", a_rd1, 64'hAA);
    check("bypass_off", b_rd1, 0);
    step();
    check("bypass_off_later", b_rd1, 64'hAA);

    we = 1'b1; waddr = 5'd0; wdata = 64'hFF; raddr1 = 5'd0;
    step();
    we = 1'b0;
    check("zero_drop", a_drop, 1);
    check("nozero_drop", c_drop, 0);
    check("zero_rd_same", a_rd1, 0);
    check("nozero_rd_same", c_rd1, 64'hFF);
    step();
    check("zero_drop_pulse", a_drop, 0);
    check("zero_rd", a_rd1, 0);
    check("nozero_rd", c_rd1, 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
